// File: rtl/aes_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// aes_cipher_ctrl
//
// Sequencer for the AES-128 Cipher core. It takes one 128-bit plaintext block
// over a valid/ready handshake, streams the 11 round keys out of the
// key-expansion word RAM, and drives the core's FSM_core / core_count / text
// inputs one cycle at a time. It then waits for cipher_dv_flag_in and holds the
// ciphertext until the consumer accepts it.
//
// Sequence: IDLE -> LOAD -> ROUND (r = 0..NUM_ROUNDS) -> FINAL -> OUT -> IDLE.
// FINAL gives up after TIMEOUT_CYC cycles, pulses error_out and returns to IDLE.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start_valid_in/_ready  plaintext handshake, pt_0_in (MSW) .. pt_3_in
//   abort_in               synchronous abort back to IDLE (reset output values)
//   rk_rd_en_out/rk_round  round-key RAM read; data on rk_x_in one cycle later
//   FSM_core_out, core_count_out, text_x_out, key_x_out   to Cipher
//   ct_x_in, cipher_dv_flag_in                            from Cipher
//   result_valid_out/result_ready_in, ct_x_out            ciphertext handshake
//   busy_out               controller not idle
//   error_out              one-cycle pulse on FINAL timeout
//
// Optional build macro AES_CTRL_PERF_EN adds blk_count_out[31:0] (completed
// handshakes) and err_count_out[15:0] (timeouts). Both counters saturate and
// only rst clears them.
// -----------------------------------------------------------------------------
module aes_cipher_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_ROUNDS  = 10,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid_in,
   output logic                  start_ready_out,
   input  logic [DATA_WIDTH-1:0] pt_0_in,
   input  logic [DATA_WIDTH-1:0] pt_1_in,
   input  logic [DATA_WIDTH-1:0] pt_2_in,
   input  logic [DATA_WIDTH-1:0] pt_3_in,
   input  logic                  abort_in,
   output logic                  rk_rd_en_out,
   output logic [3:0]            rk_round_out,
   input  logic [DATA_WIDTH-1:0] rk_0_in,
   input  logic [DATA_WIDTH-1:0] rk_1_in,
   input  logic [DATA_WIDTH-1:0] rk_2_in,
   input  logic [DATA_WIDTH-1:0] rk_3_in,
   output logic [2:0]            FSM_core_out,
   output logic [3:0]            core_count_out,
   output logic [DATA_WIDTH-1:0] text_0_out,
   output logic [DATA_WIDTH-1:0] text_1_out,
   output logic [DATA_WIDTH-1:0] text_2_out,
   output logic [DATA_WIDTH-1:0] text_3_out,
   output logic [DATA_WIDTH-1:0] key_0_out,
   output logic [DATA_WIDTH-1:0] key_1_out,
   output logic [DATA_WIDTH-1:0] key_2_out,
   output logic [DATA_WIDTH-1:0] key_3_out,
   input  logic [DATA_WIDTH-1:0] ct_0_in,
   input  logic [DATA_WIDTH-1:0] ct_1_in,
   input  logic [DATA_WIDTH-1:0] ct_2_in,
   input  logic [DATA_WIDTH-1:0] ct_3_in,
   input  logic                  cipher_dv_flag_in,
   output logic                  result_valid_out,
   input  logic                  result_ready_in,
   output logic [DATA_WIDTH-1:0] ct_0_out,
   output logic [DATA_WIDTH-1:0] ct_1_out,
   output logic [DATA_WIDTH-1:0] ct_2_out,
   output logic [DATA_WIDTH-1:0] ct_3_out,
   output logic                  busy_out,
   output logic                  error_out
`ifdef AES_CTRL_PERF_EN
   ,
   output logic [31:0]           blk_count_out,
   output logic [15:0]           err_count_out
`endif
);

   localparam int              TW         = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [3:0]      LAST_ROUND = 4'(NUM_ROUNDS);
   localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0]   TMO_ONE    = TW'(1);
   localparam logic [TW-1:0]   TMO_ZERO   = TW'(0);
   localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

   // Encodings seen by the Cipher core on FSM_core_in
   localparam logic [2:0] CORE_IDLE  = 3'b000;
   localparam logic [2:0] CORE_LOAD  = 3'b001;
   localparam logic [2:0] CORE_ROUND = 3'b010;
   localparam logic [2:0] CORE_FINAL = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ROUND = 3'd2,
      ST_FINAL = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic [3:0]    round_r, round_s;
   logic [TW-1:0] tmo_r,   tmo_s;
   logic          accept_s, capture_s, timeout_s, handshake_s;

   logic [2:0]    fsm_core_s;
   logic [3:0]    core_count_s;
   logic          rk_rd_en_s;
   logic [3:0]    rk_round_s;
   logic          start_ready_s;
   logic          busy_s;
   logic          result_valid_s;

   // The key bus is a straight pass of the RAM read data
   assign key_0_out = rk_0_in;
   assign key_1_out = rk_1_in;
   assign key_2_out = rk_2_in;
   assign key_3_out = rk_3_in;

   assign handshake_s = (state_r == ST_OUT) & result_ready_in & ~abort_in;

   // State register: FSM state, round index and FINAL timeout counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         round_r <= 4'd0;
         tmo_r   <= TMO_ZERO;
      end else begin
         state_r <= state_s;
         round_r <= round_s;
         tmo_r   <= tmo_s;
      end
   end

   // Next-state logic; abort wins over every transition
   always_comb begin
      state_s   = state_r;
      round_s   = round_r;
      tmo_s     = tmo_r;
      accept_s  = 1'b0;
      capture_s = 1'b0;
      timeout_s = 1'b0;
      if (abort_in) begin
         state_s = ST_IDLE;
         round_s = 4'd0;
         tmo_s   = TMO_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_valid_in) begin
                  accept_s = 1'b1;
                  state_s  = ST_LOAD;
               end else begin
                  state_s  = ST_IDLE;
               end
            end
            ST_LOAD: begin
               state_s = ST_ROUND;
               round_s = 4'd0;
            end
            ST_ROUND: begin
               if (round_r == LAST_ROUND) begin
                  state_s = ST_FINAL;
                  round_s = 4'd0;
                  tmo_s   = TMO_ZERO;
               end else begin
                  round_s = round_r + 4'd1;
               end
            end
            ST_FINAL: begin
               // A dv on the last allowed cycle still counts as success
               if (cipher_dv_flag_in) begin
                  capture_s = 1'b1;
                  state_s   = ST_OUT;
               end else if (tmo_r == TMO_LAST) begin
                  timeout_s = 1'b1;
                  state_s   = ST_IDLE;
                  tmo_s     = TMO_ZERO;
               end else begin
                  tmo_s     = tmo_r + TMO_ONE;
               end
            end
            ST_OUT: begin
               if (handshake_s) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_OUT;
               end
            end
            default: begin
               state_s = ST_IDLE;
               round_s = 4'd0;
               tmo_s   = TMO_ZERO;
            end
         endcase
      end
   end

   // Output decode from the upcoming state. Registering the result makes each
   // state's values visible in the same cycle the state is entered.
   always_comb begin
      fsm_core_s     = CORE_IDLE;
      core_count_s   = 4'd0;
      rk_rd_en_s     = 1'b0;
      rk_round_s     = 4'd0;
      start_ready_s  = 1'b0;
      busy_s         = 1'b1;
      result_valid_s = 1'b0;
      case (state_s)
         ST_IDLE: begin
            start_ready_s = 1'b1;
            busy_s        = 1'b0;
         end
         ST_LOAD: begin
            fsm_core_s = CORE_LOAD;
            rk_rd_en_s = 1'b1;
            rk_round_s = 4'd0;
         end
         ST_ROUND: begin
            fsm_core_s   = CORE_ROUND;
            core_count_s = round_s;
            // Prefetch the next round's key so it lands with the next count
            if (round_s < LAST_ROUND) begin
               rk_rd_en_s = 1'b1;
               rk_round_s = round_s + 4'd1;
            end else begin
               rk_rd_en_s = 1'b0;
               rk_round_s = 4'd0;
            end
         end
         ST_FINAL: begin
            fsm_core_s = CORE_FINAL;
         end
         ST_OUT: begin
            result_valid_s = 1'b1;
         end
         default: begin
            start_ready_s = 1'b1;
            busy_s        = 1'b0;
         end
      endcase
   end

   // Output register for control and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         FSM_core_out     <= CORE_IDLE;
         core_count_out   <= 4'd0;
         rk_rd_en_out     <= 1'b0;
         rk_round_out     <= 4'd0;
         start_ready_out  <= 1'b1;
         busy_out         <= 1'b0;
         result_valid_out <= 1'b0;
         error_out        <= 1'b0;
      end else begin
         FSM_core_out     <= fsm_core_s;
         core_count_out   <= core_count_s;
         rk_rd_en_out     <= rk_rd_en_s;
         rk_round_out     <= rk_round_s;
         start_ready_out  <= start_ready_s;
         busy_out         <= busy_s;
         result_valid_out <= result_valid_s;
         error_out        <= timeout_s;
      end
   end

   // Plaintext and ciphertext holding registers; abort discards both
   always_ff @(posedge clk) begin
      if (rst || abort_in) begin
         text_0_out <= WORD_ZERO;
         text_1_out <= WORD_ZERO;
         text_2_out <= WORD_ZERO;
         text_3_out <= WORD_ZERO;
         ct_0_out   <= WORD_ZERO;
         ct_1_out   <= WORD_ZERO;
         ct_2_out   <= WORD_ZERO;
         ct_3_out   <= WORD_ZERO;
      end else begin
         if (accept_s) begin
            text_0_out <= pt_0_in;
            text_1_out <= pt_1_in;
            text_2_out <= pt_2_in;
            text_3_out <= pt_3_in;
         end
         if (capture_s) begin
            ct_0_out <= ct_0_in;
            ct_1_out <= ct_1_in;
            ct_2_out <= ct_2_in;
            ct_3_out <= ct_3_in;
         end
      end
   end

`ifdef AES_CTRL_PERF_EN
   // Saturating performance counters, cleared by rst only
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_count_out <= 32'd0;
         err_count_out <= 16'd0;
      end else begin
         if (handshake_s && (blk_count_out != 32'hFFFF_FFFF)) begin
            blk_count_out <= blk_count_out + 32'd1;
         end
         if (timeout_s && (err_count_out != 16'hFFFF)) begin
            err_count_out <= err_count_out + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for aes_cipher_ctrl: key RAM model holding the AES-128 expansion
// of key 000102..0f, a Cipher stand-in that raises dv a set number of FINAL
// cycles after entry, and a cycle-timeline model of the controller.
// -----------------------------------------------------------------------------
module tb_aes_cipher_ctrl;

   localparam int TMO = 16;

   logic clk = 1'b0;
   // Free-running clock
   always #5 clk = ~clk;

   logic         rst, start_valid, abort, result_ready, dv_stub, dv_force, dv;
   logic [127:0] cur_pt, cur_ct;
   logic [31:0]  rk_0_in, rk_1_in, rk_2_in, rk_3_in;
   logic         start_ready_out, rk_rd_en_out, result_valid_out, busy_out, error_out;
   logic [3:0]   rk_round_out, core_count_out;
   logic [2:0]   FSM_core_out;
   logic [31:0]  text_0_out, text_1_out, text_2_out, text_3_out;
   logic [31:0]  key_0_out, key_1_out, key_2_out, key_3_out;
   logic [31:0]  ct_0_out, ct_1_out, ct_2_out, ct_3_out;
`ifdef AES_CTRL_PERF_EN
   logic [31:0]  blk_count_out;
   logic [15:0]  err_count_out;
`endif

   int checks = 0, failures = 0, cyc = 0;
   int dv_delay = 0, fin_n = 0, rd_cnt = 0, t_drv = 0;
   logic [31:0]  ram [44];
   logic [127:0] rk_tab [11];
   logic [127:0] fips_pt, fips_ct, pt2, ct2, pt3, ct3;

   assign dv = dv_stub | dv_force;

   aes_cipher_ctrl dut (
      .clk(clk), .rst(rst),
      .start_valid_in(start_valid), .start_ready_out(start_ready_out),
      .pt_0_in(cur_pt[127:96]), .pt_1_in(cur_pt[95:64]),
      .pt_2_in(cur_pt[63:32]),  .pt_3_in(cur_pt[31:0]),
      .abort_in(abort),
      .rk_rd_en_out(rk_rd_en_out), .rk_round_out(rk_round_out),
      .rk_0_in(rk_0_in), .rk_1_in(rk_1_in), .rk_2_in(rk_2_in), .rk_3_in(rk_3_in),
      .FSM_core_out(FSM_core_out), .core_count_out(core_count_out),
      .text_0_out(text_0_out), .text_1_out(text_1_out),
      .text_2_out(text_2_out), .text_3_out(text_3_out),
      .key_0_out(key_0_out), .key_1_out(key_1_out),
      .key_2_out(key_2_out), .key_3_out(key_3_out),
      .ct_0_in(cur_ct[127:96]), .ct_1_in(cur_ct[95:64]),
      .ct_2_in(cur_ct[63:32]),  .ct_3_in(cur_ct[31:0]),
      .cipher_dv_flag_in(dv),
      .result_valid_out(result_valid_out), .result_ready_in(result_ready),
      .ct_0_out(ct_0_out), .ct_1_out(ct_1_out), .ct_2_out(ct_2_out), .ct_3_out(ct_3_out),
      .busy_out(busy_out), .error_out(error_out)
`ifdef AES_CTRL_PERF_EN
      , .blk_count_out(blk_count_out), .err_count_out(err_count_out)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp_v, $time);
      end
   endtask

   // Cycle counter: value seen at a negedge = number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   // Key RAM: registered read, words 4r..4r+3 one cycle after the strobe
   always @(posedge clk) begin
      if (rk_rd_en_out === 1'b1) begin
         rk_0_in <= ram[4*int'(rk_round_out)+0];
         rk_1_in <= ram[4*int'(rk_round_out)+1];
         rk_2_in <= ram[4*int'(rk_round_out)+2];
         rk_3_in <= ram[4*int'(rk_round_out)+3];
      end
   end

   // Cipher stand-in: dv after dv_delay FINAL cycles (never when negative)
   always @(negedge clk) begin
      if (FSM_core_out == 3'b011) begin
         dv_stub = (dv_delay >= 0) && (fin_n == dv_delay);
         fin_n++;
      end else begin
         dv_stub = 1'b0;
         fin_n   = 0;
      end
   end

   // ---------------- Reference model (timeline since block acceptance) -------
   // m_k: -1 idle, 1 = LOAD cycle, 2..12 = round k-2, >=13 = FINAL cycle k-13
   int           m_k = -1, m_blk = 0, m_errc = 0;
   bit           m_hold = 1'b0, m_err = 1'b0, m_ok = 1'b0;
   logic [127:0] m_text = '0, m_ct = '0;

   function automatic logic [2:0] e_fsm(input int k);
      if (k == 1) return 3'b001;
      if (k >= 2 && k <= 12) return 3'b010;
      if (k >= 13) return 3'b011;
      return 3'b000;
   endfunction

   // Compare DUT against the model, then advance the model with the inputs
   // that the next rising edge will sample
   always begin
      @(negedge clk);
      #2;
      if (m_ok) begin
         chk("busy", busy_out, 32'((m_k >= 1) || m_hold));
         chk("start_ready", start_ready_out, 32'(!((m_k >= 1) || m_hold)));
         chk("result_valid", result_valid_out, 32'(m_hold));
         chk("error", error_out, 32'(m_err));
         chk("fsm_core", FSM_core_out, 32'(e_fsm(m_k)));
         chk("core_count", core_count_out, (m_k >= 2 && m_k <= 12) ? 32'(m_k - 2) : 32'd0);
         chk("rk_rd_en", rk_rd_en_out, 32'((m_k == 1) || (m_k >= 2 && m_k <= 11)));
         chk("rk_round", rk_round_out, (m_k >= 2 && m_k <= 11) ? 32'(m_k - 1) : 32'd0);
         chk("text0", text_0_out, m_text[127:96]);
         chk("text1", text_1_out, m_text[95:64]);
         chk("text2", text_2_out, m_text[63:32]);
         chk("text3", text_3_out, m_text[31:0]);
         chk("ct0", ct_0_out, m_ct[127:96]);
         chk("ct1", ct_1_out, m_ct[95:64]);
         chk("ct2", ct_2_out, m_ct[63:32]);
         chk("ct3", ct_3_out, m_ct[31:0]);
         if (m_k >= 2 && m_k <= 12) begin
            chk("key0", key_0_out, ram[4*(m_k-2)+0]);
            chk("key1", key_1_out, ram[4*(m_k-2)+1]);
            chk("key2", key_2_out, ram[4*(m_k-2)+2]);
            chk("key3", key_3_out, ram[4*(m_k-2)+3]);
         end
`ifdef AES_CTRL_PERF_EN
         chk("blk_count", blk_count_out, 32'(m_blk));
         chk("err_count", 32'(err_count_out), 32'(m_errc));
`endif
      end
      m_err = 1'b0;
      if (rst) begin
         m_k = -1; m_hold = 1'b0; m_text = '0; m_ct = '0; m_blk = 0; m_errc = 0;
      end else if (abort) begin
         m_k = -1; m_hold = 1'b0; m_text = '0; m_ct = '0;
      end else if (m_hold) begin
         if (result_ready) begin
            m_hold = 1'b0;
            m_blk++;
         end
      end else if (m_k < 0) begin
         if (start_valid) begin
            m_k = 1;
            m_text = cur_pt;
         end
      end else if (m_k <= 12) begin
         m_k++;
      end else if (dv) begin
         m_hold = 1'b1; m_k = -1; m_ct = cur_ct;
      end else if (m_k - 13 == TMO - 1) begin
         m_err = 1'b1; m_k = -1; m_errc++;
      end else begin
         m_k++;
      end
      m_ok = 1'b1;
   end

   // ---------------- Stimulus helpers ----------------------------------------
   task automatic do_start(input logic [127:0] pt, input logic [127:0] ct, input int dly);
      cur_pt = pt; cur_ct = ct; dv_delay = dly; rd_cnt = 0; t_drv = cyc;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   task automatic wait_valid(output int at);
      at = -1;
      for (int i = 0; i < 60; i++) begin
         if (rk_rd_en_out) rd_cnt++;
         if (FSM_core_out == 3'b010 && core_count_out == 4'd0)
            chk("key_r0_literal", key_0_out, 32'h0001_0203);
         if (FSM_core_out == 3'b010 && core_count_out == 4'd10)
            chk("key_r10_literal", key_3_out, 32'h4d2b_30c5);
         if (result_valid_out) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
      if (at < 0) begin
         checks++; failures++;
         $display("FAIL wait_valid actual=no_valid required=valid_within_60_cycles");
      end
   endtask

   task automatic wait_final(output int at);
      at = -1;
      for (int i = 0; i < 30; i++) begin
         if (FSM_core_out == 3'b011) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
      if (at < 0) begin
         checks++; failures++;
         $display("FAIL wait_final actual=no_final required=final_within_30_cycles");
      end
   endtask

   // Safety net against a hung run
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- Directed test sequence ----------------------------------
   initial begin
      int at, fin_at, err_at, vseen, hit;
      rk_tab = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                 128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
                 128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
                 128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
                 128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
                 128'h13111d7fe3944a17f307a78b4d2b30c5};
      for (int r = 0; r < 11; r++)
         for (int w = 0; w < 4; w++)
            ram[4*r+w] = rk_tab[r][127-32*w -: 32];
      fips_pt = 128'h00112233_44556677_8899aabb_ccddeeff;
      fips_ct = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
      pt2 = 128'h01234567_89abcdef_fedcba98_76543210;
      ct2 = 128'hdeadbeef_cafef00d_a5a55a5a_0badc0de;
      pt3 = 128'h11111111_22222222_33333333_44444444;
      ct3 = 128'h55555555_66666666_77777777_88888888;

      rst = 1'b1; start_valid = 1'b0; abort = 1'b0; result_ready = 1'b1;
      dv_force = 1'b0; cur_pt = '0; cur_ct = '0; dv_delay = 0;
      repeat (3) @(negedge clk);
      chk("rst_start_ready", start_ready_out, 32'd1);
      chk("rst_fsm_core", FSM_core_out, 32'd0);
      chk("rst_busy", busy_out, 32'd0);
      chk("rst_valid", result_valid_out, 32'd0);
      chk("rst_rd_en", rk_rd_en_out, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 C.1 block, dv on the first FINAL cycle
      do_start(fips_pt, fips_ct, 0);
      wait_valid(at);
      chk("fips_latency", at, t_drv + 14);
      chk("fips_rd_pulses", rd_cnt, 32'd11);
      chk("fips_ct0", ct_0_out, 32'h69c4e0d8);
      chk("fips_ct1", ct_1_out, 32'h6a7b0430);
      chk("fips_ct2", ct_2_out, 32'hd8cdb780);
      chk("fips_ct3", ct_3_out, 32'h70b4c55a);
      @(negedge clk);
      chk("fips_valid_drop", result_valid_out, 32'd0);
      chk("fips_ready_back", start_ready_out, 32'd1);

      // Back-pressure: consumer stalls 20 cycles; a start offered meanwhile
      result_ready = 1'b0;
      do_start(pt2, ct2, 3);
      wait_valid(at);
      chk("bp_latency", at, t_drv + 17);
      start_valid = 1'b1;
      repeat (20) @(negedge clk);
      start_valid = 1'b0;
      chk("bp_valid_held", result_valid_out, 32'd1);
      chk("bp_ready_low", start_ready_out, 32'd0);
      chk("bp_ct0_stable", ct_0_out, 32'hdeadbeef);
      chk("bp_ct3_stable", ct_3_out, 32'h0badc0de);
      result_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drop", result_valid_out, 32'd0);
      chk("bp_ready_back", start_ready_out, 32'd1);

      // dv while idle must be ignored
      dv_force = 1'b1;
      @(negedge clk);
      dv_force = 1'b0;
      @(negedge clk);
      chk("idle_dv_ignored", result_valid_out, 32'd0);

      // Timeout: core never answers; a second start mid-block is ignored
      do_start(pt3, ct3, -1);
      cur_pt = pt2;
      start_valid = 1'b1;
      repeat (3) @(negedge clk);
      start_valid = 1'b0;
      chk("busy_start_ignored", text_0_out, 32'h11111111);
      wait_final(fin_at);
      err_at = -1; vseen = 0;
      for (int i = 0; i < 40; i++) begin
         if (result_valid_out) vseen++;
         if (error_out) begin
            err_at = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("tmo_error_time", err_at, fin_at + 16);
      chk("tmo_no_valid", vseen, 32'd0);
      chk("tmo_idle_ready", start_ready_out, 32'd1);
      @(negedge clk);
      chk("tmo_error_pulse", error_out, 32'd0);
      chk("tmo_not_busy", busy_out, 32'd0);

      // Abort in round 5, then a fresh block completes
      do_start(fips_pt, fips_ct, 0);
      hit = 0;
      for (int i = 0; i < 30; i++) begin
         if (FSM_core_out == 3'b010 && core_count_out == 4'd5) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      chk("abort_reached_r5", hit, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_fsm_core", FSM_core_out, 32'd0);
      chk("abort_busy", busy_out, 32'd0);
      chk("abort_text_clr", text_0_out, 32'd0);
      chk("abort_error", error_out, 32'd0);
      @(negedge clk);
      do_start(fips_pt, fips_ct, 1);
      wait_valid(at);
      chk("post_abort_latency", at, t_drv + 15);
      chk("post_abort_ct0", ct_0_out, 32'h69c4e0d8);
      chk("post_abort_ct3", ct_3_out, 32'h70b4c55a);
      @(negedge clk);

      // rst together with dv in FINAL
      do_start(pt2, ct2, 0);
      wait_final(fin_at);
      rst = 1'b1;
      @(negedge clk);
      chk("rstf_valid", result_valid_out, 32'd0);
      chk("rstf_fsm_core", FSM_core_out, 32'd0);
      chk("rstf_ct0", ct_0_out, 32'd0);
      chk("rstf_ready", start_ready_out, 32'd1);
`ifdef AES_CTRL_PERF_EN
      chk("rstf_blk_count", blk_count_out, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("rstf_no_late_valid", result_valid_out, 32'd0);
      for (int b = 0; b < 2; b++) begin
         do_start(fips_pt, fips_ct, 0);
         wait_valid(at);
         @(negedge clk);
      end
`ifdef AES_CTRL_PERF_EN
      chk("perf_blk_two", blk_count_out, 32'd2);
      chk("perf_err_zero", 32'(err_count_out), 32'd0);
`endif
      chk("final_ct1", ct_1_out, 32'h6a7b0430);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
